// File: rtl/fifo_wr_sched_pkg.sv
// Shared types and constants for the FIFO write-side scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    RST_ASSERT = 2'd0,
    RST_WAIT   = 2'd1,
    RUN        = 2'd2
  } sched_state_e;

  localparam int RST_WAIT_GUARD = 2;

  // Smallest r with 2**r >= v; evaluated at elaboration time.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Producer and FIFO write-port signals seen by the scheduler.
interface fifo_wr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = fifo_sched_pkg::clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      flush;
  logic [NUM_REQ-1:0]        gnt;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      ready;
  logic                      fifo_srst;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_wr_en;
  logic                      fifo_full;
  logic                      fifo_wr_rst_busy;
  logic                      fifo_rd_rst_busy;

  modport slave (
    input  req, req_data, flush, fifo_full, fifo_wr_rst_busy, fifo_rd_rst_busy,
    output gnt, gnt_idx, ready, fifo_srst, fifo_din, fifo_wr_en
  );

  modport master (
    output req, req_data, flush, fifo_full, fifo_wr_rst_busy, fifo_rd_rst_busy,
    input  gnt, gnt_idx, ready, fifo_srst, fifo_din, fifo_wr_en
  );
endinterface

// File: rtl/fifo_wr_sched_rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer,
// take the lowest set bit, rotate the index back.
module rr_pick import fifo_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [IDX_W-1:0]     pos_s;
  logic                 found_s;
  logic [IDX_W:0]       sum_s;

  // Rotated priority search and back-rotation of the winning index.
  always_comb begin
    dbl_s   = {req_i, req_i} >> rr_ptr_i;
    rot_s   = dbl_s[NUM_REQ-1:0];
    pos_s   = '0;
    found_s = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        pos_s   = IDX_W'(i);
        found_s = 1'b1;
      end
    end
    sum_s = {1'b0, pos_s} + {1'b0, rr_ptr_i};
    if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
      sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
    end else begin
      sum_s = sum_s;
    end
    if (en_i && found_s) begin
      gnt_idx_o = sum_s[IDX_W-1:0];
      gnt_o     = {{(NUM_REQ-1){1'b0}}, 1'b1} << sum_s[IDX_W-1:0];
    end else begin
      gnt_idx_o = '0;
      gnt_o     = '0;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// FIFO write-port scheduler: reset/flush sequencing of the FIFO and
// round-robin sharing of its write port among NUM_REQ producers.
module fifo_wr_sched import fifo_sched_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int RST_CYCLES = 4,
  parameter int IDX_W      = clog2(NUM_REQ)
) (
  input logic            clk,
  input logic            srst_n,
  fifo_wr_sched_if.slave bus
);

  localparam int CNT_W = clog2(RST_CYCLES + RST_WAIT_GUARD + 1);

  sched_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               ready_q, fifo_srst_q;
  logic               grant_en_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [DATA_W-1:0]  din_s;

  // srst_n gates the grant directly so an in-flight write dies with reset.
  assign grant_en_s = srst_n && (state_q == RUN) && !bus.fifo_full && !bus.flush;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .en_i      (grant_en_s),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Winner data mux; zero when nothing is granted.
  always_comb begin
    din_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        din_s = bus.req_data[i*DATA_W +: DATA_W];
      end else begin
        din_s = din_s;
      end
    end
  end

  // Reset/flush sequencing next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST_ASSERT: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = RST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RST_WAIT: begin
        if (cnt_q < CNT_W'(RST_WAIT_GUARD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!bus.fifo_wr_rst_busy && !bus.fifo_rd_rst_busy) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = RST_ASSERT;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Round-robin pointer next state.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if ((state_q == RUN) && bus.flush) begin
      rr_ptr_d = '0;
    end else if (|gnt_s) begin
      if (gnt_idx_s == IDX_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx_s + IDX_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State, counter, pointer and registered status outputs.
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= RST_ASSERT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      ready_q     <= 1'b0;
      fifo_srst_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ready_q     <= (state_d == RUN);
      fifo_srst_q <= (state_d == RST_ASSERT);
    end
  end

  assign bus.gnt        = gnt_s;
  assign bus.gnt_idx    = gnt_idx_s;
  assign bus.fifo_wr_en = |gnt_s;
  assign bus.fifo_din   = din_s;
  assign bus.ready      = ready_q;
  assign bus.fifo_srst  = fifo_srst_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Bench for fifo_wr_sched: vector table for arbitration plus hand-written
// reset, flush and mid-stream reset sequences; data checked via a scoreboard.
module tb_fifo_wr_sched;

  logic clk;
  logic srst_n;

  fifo_wr_sched_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  fifo_wr_sched #(.NUM_REQ(4), .DATA_W(32), .RST_CYCLES(4)) dut (
    .clk    (clk),
    .srst_n (srst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] exp_gnt;
  } vec_t;

  int          vecs;
  int          miscompares;
  logic [31:0] prod_data [4];
  logic [31:0] sb_q [$];
  vec_t        tbl [$];

  function automatic logic [31:0] oh2idx(input logic [3:0] oh);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 32'(i);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_data(input logic [31:0] base);
    for (int i = 0; i < 4; i++) prod_data[i] = base + 32'(i);
    bus.req_data = {prod_data[3], prod_data[2], prod_data[1], prod_data[0]};
  endtask

  // One clock cycle: drive, push expected write, sample on negedge, advance.
  task automatic step(input logic [3:0] r, input logic fl, input logic fu,
                      input logic [3:0] eg, input logic er, input logic es,
                      input string nm);
    logic [31:0] exp_d;
    bus.req       = r;
    bus.flush     = fl;
    bus.fifo_full = fu;
    if (|eg) sb_q.push_back(prod_data[oh2idx(eg)]);
    @(negedge clk);
    check({nm, "_gnt"},   32'(bus.gnt),        32'(eg));
    check({nm, "_idx"},   32'(bus.gnt_idx),    oh2idx(eg));
    check({nm, "_wr"},    32'(bus.fifo_wr_en), 32'(|eg));
    check({nm, "_ready"}, 32'(bus.ready),      32'(er));
    check({nm, "_srst"},  32'(bus.fifo_srst),  32'(es));
    if (bus.fifo_wr_en) begin
      if (sb_q.size() == 0) begin
        vecs++;
        miscompares++;
        $display("FAIL %s_sb: unexpected write din=%h, nothing expected", nm, bus.fifo_din);
      end else begin
        exp_d = sb_q.pop_front();
        check({nm, "_din"}, bus.fifo_din, exp_d);
      end
    end else begin
      check({nm, "_din0"}, bus.fifo_din, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    srst_n      = 1'b0;
    bus.req     = 4'b0000;
    bus.flush   = 1'b0;
    bus.fifo_full        = 1'b0;
    bus.fifo_wr_rst_busy = 1'b1;
    bus.fifo_rd_rst_busy = 1'b1;
    load_data(32'h0000_00A0);

    // Reset hold (3 cycles low), requests asserted but suppressed.
    @(posedge clk);
    #1;
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "rst_hold");
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "rst_hold");

    // Release; wr busy clears at 7, rd busy at 10 -> RUN/ready at 11.
    srst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      bus.fifo_wr_rst_busy = (c < 7);
      bus.fifo_rd_rst_busy = (c < 10);
      step((c < 10) ? 4'b1111 : 4'b0000, 1'b0, 1'b0, 4'b0000,
           (c >= 11), (c < 4), "rst_seq");
    end

    // Arbitration table, starting with rr_ptr=0.
    tbl = '{
      '{4'b1111, 1'b0, 4'b0001}, '{4'b1111, 1'b0, 4'b0010},
      '{4'b1111, 1'b0, 4'b0100}, '{4'b1111, 1'b0, 4'b1000},
      '{4'b1111, 1'b0, 4'b0001},
      '{4'b0101, 1'b0, 4'b0100}, '{4'b0101, 1'b0, 4'b0001},
      '{4'b0101, 1'b0, 4'b0100}, '{4'b0101, 1'b0, 4'b0001},
      '{4'b0010, 1'b0, 4'b0010}, '{4'b0010, 1'b0, 4'b0010},
      '{4'b0010, 1'b0, 4'b0010},
      '{4'b1111, 1'b1, 4'b0000}, '{4'b1111, 1'b1, 4'b0000},
      '{4'b1111, 1'b1, 4'b0000}, '{4'b1111, 1'b1, 4'b0000},
      '{4'b1111, 1'b1, 4'b0000},
      '{4'b1111, 1'b0, 4'b0100}, '{4'b1111, 1'b0, 4'b1000},
      '{4'b0000, 1'b0, 4'b0000}, '{4'b1000, 1'b0, 4'b1000},
      '{4'b0110, 1'b0, 4'b0010}, '{4'b0110, 1'b0, 4'b0100},
      '{4'b0110, 1'b0, 4'b0010}
    };
    foreach (tbl[i]) begin
      step(tbl[i].req, 1'b0, tbl[i].full, tbl[i].exp_gnt, 1'b1, 1'b0, "tbl");
    end

    // Flush collision: ptr is 2 before flush; flush in RST_WAIT is ignored.
    step(4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, "fl_pre");
    step(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, "fl_hit");
    for (int c = 1; c < 10; c++) begin
      step(4'b1111, (c == 6), 1'b0,
           (c == 8) ? 4'b0001 : ((c == 9) ? 4'b0010 : 4'b0000),
           (c >= 8), (c >= 1 && c <= 4), "fl_seq");
    end

    // Mid-stream reset with fresh producer data.
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ms_idle");
    load_data(32'h0000_00B0);
    step(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, "ms_run");
    step(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, "ms_run");
    step(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, "ms_run");
    srst_n = 1'b0;
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, "ms_rst");
    step(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "ms_hold");
    srst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step(4'b1111, 1'b0, 1'b0,
           (c == 7) ? 4'b0001 : ((c == 8) ? 4'b0010 : 4'b0000),
           (c >= 7), (c < 4), "ms_rec");
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_sched.md
Name: fifo_wr_sched

Overview:
- Write-side scheduler for the shared 32-bit single-clock FIFO (fifo_generator_0 instance).
- Shares the FIFO write port between NUM_REQ producers using round-robin arbitration.
- Sequences FIFO reset: drives srst, waits out wr_rst_busy/rd_rst_busy, and supports a runtime flush.
- Sits between the producer blocks and the FIFO wrapper; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 32, FIFO data width
- RST_CYCLES, 4, clock cycles fifo_srst is held high per reset/flush (>=1)
- IDX_W, $clog2(NUM_REQ), width of requester index

Ports:
- clk  in  1  single clock, all logic rising-edge
- srst_n  in  1  synchronous reset, active-low
- req  in  NUM_REQ  per-producer request; held with data until gnt
- req_data  in  NUM_REQ*DATA_W  producer i's data at bits [i*DATA_W +: DATA_W]
- flush  in  1  single-cycle pulse: reset FIFO contents at runtime
- gnt  out  NUM_REQ  one-hot, combinational; producer's word written this cycle
- gnt_idx  out  IDX_W  index of the current winner; 0 when no grant
- ready  out  1  registered; high in RUN state only
- fifo_srst  out  1  registered, active-high, to FIFO srst
- fifo_din  out  DATA_W  combinational mux of the winner's data; 0 when no grant
- fifo_wr_en  out  1  combinational; equals |gnt
- fifo_full  in  1  FIFO full
- fifo_wr_rst_busy  in  1  FIFO write-reset busy
- fifo_rd_rst_busy  in  1  FIFO read-reset busy

Behaviour:
- FSM states: RST_ASSERT, RST_WAIT, RUN.
- srst_n low (sampled at clk):
  - state=RST_ASSERT, cnt=0, rr_ptr=0.
  - fifo_srst=1, ready=0.
  - gnt=0, fifo_wr_en=0, fifo_din=0.
- RST_ASSERT:
  - fifo_srst=1; cnt increments each cycle.
  - When cnt==RST_CYCLES-1, go to RST_WAIT, clear cnt, fifo_srst=0.
  - fifo_srst is therefore high exactly RST_CYCLES cycles after the srst_n release or flush entry.
- RST_WAIT:
  - fifo_srst=0; cnt counts to 2 (busy-assertion guard).
  - After the guard, go to RUN on the first cycle with fifo_wr_rst_busy==0 and fifo_rd_rst_busy==0; ready rises the following cycle.
  - No timeout: busy stuck high holds the block in RST_WAIT.
- RUN: grant is enabled when state==RUN && !fifo_full && !flush && |req.
- Winner selection:
  - Search from rr_ptr upward, wrapping modulo NUM_REQ; the first set req bit wins.
  - gnt is one-hot for that index; zero-latency write (fifo_wr_en and fifo_din in the same cycle as gnt).
- Pointer update: on a grant to index i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Producer handshake: a producer seeing gnt[i]=1 may drop req or present the next word next cycle. A producer must not change req_data while req=1 && gnt=0.
- fifo_full=1: no grant, no write, pointer frozen. The pending winner is re-evaluated when full clears; fairness order is unchanged.
- flush in RUN:
  - Flush beats a grant in the same cycle (gnt=0).
  - Next state is RST_ASSERT; ready falls the next cycle and rr_ptr resets to 0.
  - Flush outside RUN is ignored.
- Throughput: one word per cycle while not full, including back-to-back from one producer if it is the only requester.
- Mid-operation srst_n: takes effect the next edge regardless of state; any in-flight grant that cycle is suppressed.

Decomposition:
- Package fifo_sched_pkg holds the state enum (RST_ASSERT, RST_WAIT, RUN), RST_WAIT_GUARD=2, and a clog2 helper.
- Sub-module rr_pick:
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot gnt and gnt_idx.
  - Pure combinational rotate-priority-rotate.
  - Parent owns rr_ptr, FSM and muxing.

Test Plan:
- Reset sequencing: srst_n low 3 cycles, then high; busy inputs high 10 cycles after release -> fifo_srst high for exactly 4 cycles after release; ready=0 until the cycle after both busy flags are low and the guard has elapsed; no gnt before ready.
- Full rotation: req=4'b1111 held, full=0, data 0xA0..0xA3 -> gnt 0001, 0010, 0100, 1000, 0001 on consecutive cycles; fifo_din 0xA0, 0xA1, 0xA2, 0xA3, 0xA0; fifo_wr_en=1 every cycle.
- Sparse fairness: req=4'b0101 held -> gnt alternates 0001, 0100; gnt_idx alternates 0, 2; req[1] and req[3] never granted.
- Full stall: after a grant to 1, set fifo_full=1 for 5 cycles with req=4'b1111 -> gnt=0, wr_en=0 throughout; on full=0 the first gnt is 0100 (index 2).
- Flush collision: flush pulse in the same cycle as req=4'b0001 in RUN -> gnt=0 that cycle, ready=0 next cycle, fifo_srst high 4 cycles, then RST_WAIT and RUN; first post-flush grant is index 0.
- Mid-stream reset: srst_n low while req=4'b1111 streaming -> gnt/fifo_wr_en=0 from that edge; fifo_srst=1; rr_ptr=0 after recovery, so the first grant is index 0.
